// File: rtl/z80_bus_pkg.sv
// Shared definitions for the Z80 bus initiator: request op codes, bus state
// encoding, the strobe bundle and the refresh address layout.
package z80_bus_pkg;

  // Request op encoding (values 5..7 are illegal)
  localparam logic [2:0] OP_MEMRD = 3'd0;
  localparam logic [2:0] OP_MEMWR = 3'd1;
  localparam logic [2:0] OP_IORD  = 3'd2;
  localparam logic [2:0] OP_IOWR  = 3'd3;
  localparam logic [2:0] OP_FETCH = 3'd4;

  // One state per T-state of a Z80 machine cycle; TWA is the automatic IO wait
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T1,
    ST_T2,
    ST_TWA,
    ST_TW,
    ST_T3,
    ST_T4
  } state_e;

  // Active-low bus strobes, bundled so they can be registered as one value
  typedef struct packed {
    logic mreq_b;
    logic ioreq_b;
    logic rd_b;
    logic wr_b;
    logic m1_b;
    logic rfsh_b;
  } strobes_t;

  localparam strobes_t STROBES_IDLE = '1;

  // Refresh address: 7-bit R counter in the low bits, upper bits zero
  localparam int REFRESH_R_W   = 7;
  localparam int REFRESH_PAD_W = 16 - REFRESH_R_W;

  function automatic logic [15:0] refresh_addr(input logic [REFRESH_R_W-1:0] r);
    return {{REFRESH_PAD_W{1'b0}}, r};
  endfunction

  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= OP_FETCH;
  endfunction

  function automatic logic op_is_io(input logic [2:0] op);
    return (op == OP_IORD) || (op == OP_IOWR);
  endfunction

  function automatic logic op_is_write(input logic [2:0] op);
    return (op == OP_MEMWR) || (op == OP_IOWR);
  endfunction

  // Any op that drives RD_B low (includes opcode fetch)
  function automatic logic op_is_read(input logic [2:0] op);
    return (op == OP_MEMRD) || (op == OP_IORD) || (op == OP_FETCH);
  endfunction

endpackage

// File: rtl/z80_wait_timer.sv
// Counts READY-low wait states of one bus cycle and flags a timeout once
// MAX_WAIT wait states have elapsed with READY still low.
module z80_wait_timer #(
  parameter int MAX_WAIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,        // restart for a new bus cycle
  input  logic step,       // READY sampled low at a sampling point
  output logic expired,    // count has reached MAX_WAIT
  output logic timed_out   // READY was still low with the count at MAX_WAIT
);

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

  logic [7:0] count;

  assign expired = (count == LIMIT);

  // Wait counter and sticky timeout flag, restarted at the start of each cycle
  always_ff @(posedge clk) begin
    // NOTE: every register here is assigned with <= so all of them update from
    // the same pre-edge values; a blocking = would let later lines see new ones.
    if (rst) begin
      count     <= 8'd0;
      timed_out <= 1'b0;
    end else if (clr) begin
      count     <= 8'd0;
      timed_out <= 1'b0;
    end else if (step) begin
      if (expired) timed_out <= 1'b1;
      else         count     <= count + 8'd1;
    end
  end

endmodule

// File: rtl/z80_bus_initiator.sv
// Z80 bus cycle generator: turns single-transfer requests into memory, IO and
// opcode-fetch machine cycles with READY wait states and refresh.
module z80_bus_initiator
  import z80_bus_pkg::*;
#(
  parameter int MAX_WAIT     = 255,
  parameter bit IO_AUTO_WAIT = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] A,
  output logic [7:0]  D_OUT,
  output logic        D_OE,
  input  logic [7:0]  D_IN,
  output logic        MREQ_B,
  output logic        IOREQ_B,
  output logic        RD_B,
  output logic        WR_B,
  output logic        M1_B,
  output logic        RFSH_B,
  input  logic        READY
);

  state_e      state, state_nxt;
  logic [2:0]  op_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  fetch_q;
  logic [REFRESH_R_W-1:0] r_q;
  strobes_t    strobes_q, strobes_nxt;
  logic [15:0] a_nxt;
  logic [7:0]  dout_nxt;
  logic        doe_nxt;

  logic        accept;
  logic [2:0]  cur_op;
  logic [15:0] cur_addr;
  logic [7:0]  cur_wdata;
  logic        io_auto;
  logic        sample_ready;
  logic        wait_step;
  logic        wait_expired;
  logic        timed_out;
  logic        completing;

  assign accept  = req_valid & req_ready;
  assign io_auto = IO_AUTO_WAIT && op_is_io(op_q);

  // READY is looked at on the last T2 (unless IO auto-waits), TWA and each TW
  assign sample_ready = ((state == ST_T2) && !io_auto) ||
                        (state == ST_TWA) || (state == ST_TW);
  assign wait_step    = sample_ready & ~READY;

  // A bus cycle ends when the FSM drops back to IDLE from T3 or T4
  assign completing = (state != ST_IDLE) && (state_nxt == ST_IDLE);

  z80_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk       (CLK),
    .rst       (RESET),
    .clr       (state == ST_T1),
    .step      (wait_step),
    .expired   (wait_expired),
    .timed_out (timed_out)
  );

  // Request fields as seen by the next state: live on the accept edge, else registered
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    cur_op    = op_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (accept) begin
      cur_op    = req_op;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end
  end

  // Next-state sequencing through T1, T2, wait states, T3 and refresh T4
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = op_is_legal(req_op) ? ST_T1 : ST_IDLE;
      ST_T1:   state_nxt = ST_T2;
      ST_T2: begin
        if (io_auto)    state_nxt = ST_TWA;
        else if (READY) state_nxt = ST_T3;
        else            state_nxt = ST_TW;
      end
      ST_TWA:  state_nxt = READY ? ST_T3 : ST_TW;
      ST_TW:   state_nxt = (READY || wait_expired) ? ST_T3 : ST_TW;
      ST_T3:   state_nxt = (op_q == OP_FETCH) ? ST_T4 : ST_IDLE;
      ST_T4:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bus pin values for the state about to be entered, registered below
  always_comb begin
    strobes_nxt = STROBES_IDLE;
    a_nxt       = A;
    dout_nxt    = D_OUT;
    doe_nxt     = 1'b0;
    case (state_nxt)
      ST_T1: begin
        a_nxt              = cur_addr;
        doe_nxt            = op_is_write(cur_op);
        dout_nxt           = cur_wdata;
        strobes_nxt.m1_b   = (cur_op != OP_FETCH);
      end
      ST_T2, ST_TWA, ST_TW, ST_T3: begin
        if ((state_nxt == ST_T3) && (cur_op == OP_FETCH)) begin
          a_nxt              = refresh_addr(r_q);
          strobes_nxt.rfsh_b = 1'b0;
        end else begin
          a_nxt               = cur_addr;
          doe_nxt             = op_is_write(cur_op);
          dout_nxt            = cur_wdata;
          strobes_nxt.mreq_b  = op_is_io(cur_op);
          strobes_nxt.ioreq_b = !op_is_io(cur_op);
          strobes_nxt.rd_b    = !op_is_read(cur_op);
          strobes_nxt.wr_b    = !op_is_write(cur_op);
          strobes_nxt.m1_b    = (cur_op != OP_FETCH);
        end
      end
      ST_T4: begin
        a_nxt              = refresh_addr(r_q);
        strobes_nxt.rfsh_b = 1'b0;
        strobes_nxt.mreq_b = 1'b0;
      end
      default: ;
    endcase
  end

  // Single registered FSM: state, request capture, bus pins and response
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      op_q      <= OP_MEMRD;
      addr_q    <= 16'h0000;
      wdata_q   <= 8'h00;
      fetch_q   <= 8'h00;
      r_q       <= '0;
      strobes_q <= STROBES_IDLE;
      A         <= 16'h0000;
      D_OUT     <= 8'h00;
      D_OE      <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      state     <= state_nxt;
      strobes_q <= strobes_nxt;
      A         <= a_nxt;
      D_OUT     <= dout_nxt;
      D_OE      <= doe_nxt;
      req_ready <= (state_nxt == ST_IDLE);

      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end

      // Opcode byte is taken on the last T2/TW, before refresh takes the bus
      if ((op_q == OP_FETCH) && (state_nxt == ST_T3) &&
          ((state == ST_T2) || (state == ST_TW)))
        fetch_q <= D_IN;

      if ((state == ST_T3) && ((op_q == OP_MEMRD) || (op_q == OP_IORD)))
        rsp_rdata <= D_IN;
      else if (state == ST_T4)
        rsp_rdata <= fetch_q;

      if (state == ST_T4)
        r_q <= r_q + 1'b1;

      if (accept && !op_is_legal(req_op)) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
      end else begin
        rsp_valid <= completing;
        rsp_err   <= completing & timed_out;
      end
    end
  end

  assign MREQ_B  = strobes_q.mreq_b;
  assign IOREQ_B = strobes_q.ioreq_b;
  assign RD_B    = strobes_q.rd_b;
  assign WR_B    = strobes_q.wr_b;
  assign M1_B    = strobes_q.m1_b;
  assign RFSH_B  = strobes_q.rfsh_b;

endmodule

// File: tb/tb_z80_bus_initiator.sv
// Scoreboard bench for z80_bus_initiator: the driver queues the expected
// response of each request, a monitor tallies bus strobes per cycle and checks
// them against the queue head whenever rsp_valid pulses.
module tb_z80_bus_initiator;
  import z80_bus_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [15:0] req_addr = 16'h0000;
  logic [7:0]  req_wdata = 8'h00;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [15:0] A;
  logic [7:0]  D_OUT;
  logic        D_OE;
  logic [7:0]  D_IN;
  logic        MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B;
  logic        READY = 1'b1;

  always #5 CLK = ~CLK;

  z80_bus_initiator #(.MAX_WAIT(4), .IO_AUTO_WAIT(1'b1)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .A(A), .D_OUT(D_OUT), .D_OE(D_OE), .D_IN(D_IN),
    .MREQ_B(MREQ_B), .IOREQ_B(IOREQ_B), .RD_B(RD_B), .WR_B(WR_B),
    .M1_B(M1_B), .RFSH_B(RFSH_B), .READY(READY)
  );

  typedef struct {
    string       name;
    int          lat;
    int          cyc;
    logic        err;
    logic [7:0]  rdata;
    int          mreq, ioreq, rd, wr, m1, rfsh, doe;
    logic [7:0]  dout;
    logic [15:0] addr;
    logic [15:0] refa;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input string nm, input int lat, input logic err,
                              input logic [7:0] rdata, input int mreq, input int ioreq,
                              input int rd, input int wr, input int m1, input int rfsh,
                              input int doe, input logic [7:0] dout,
                              input logic [15:0] addr, input logic [15:0] refa);
    exp_t e;
    e.name = nm; e.lat = lat; e.cyc = 0; e.err = err; e.rdata = rdata;
    e.mreq = mreq; e.ioreq = ioreq; e.rd = rd; e.wr = wr; e.m1 = m1;
    e.rfsh = rfsh; e.doe = doe; e.dout = dout; e.addr = addr; e.refa = refa;
    return e;
  endfunction

  // Bus responder: read data only while RD_B is low; READY held low for the
  // first ready_low_n strobed T-states of each cycle
  logic [7:0] bus_data = 8'h00;
  int         ready_low_n = 0;
  int         seen = 0;

  assign D_IN = RD_B ? 8'hFF : bus_data;

  always @(negedge CLK) begin
    if (req_ready) seen = 0;
    else if ((!RD_B || !WR_B) && RFSH_B) seen = seen + 1;
    READY = (seen > ready_low_n);
  end

  // Monitor: per-cycle strobe tallies, compared at each completion
  int          c_mreq, c_ioreq, c_rd, c_wr, c_m1, c_rfsh, c_doe;
  logic [7:0]  c_dout;
  logic [15:0] c_addr, c_refa;
  exp_t        mon_e;

  task automatic clear_tally();
    c_mreq = 0; c_ioreq = 0; c_rd = 0; c_wr = 0; c_m1 = 0; c_rfsh = 0; c_doe = 0;
    c_dout = 8'h00; c_addr = 16'h0000; c_refa = 16'h0000;
  endtask

  initial clear_tally();

  always @(negedge CLK) begin
    if (RESET) begin
      clear_tally();
    end else begin
      c_mreq  += int'(!MREQ_B);
      c_ioreq += int'(!IOREQ_B);
      c_rd    += int'(!RD_B);
      c_wr    += int'(!WR_B);
      c_m1    += int'(!M1_B);
      c_rfsh  += int'(!RFSH_B);
      c_doe   += int'(D_OE);
      if (D_OE) c_dout = D_OUT;
      if ((!MREQ_B || !IOREQ_B) && RFSH_B) c_addr = A;
      if (!RFSH_B) c_refa = A;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check({mon_e.name, ".latency_cycle"}, 32'(cyc), 32'(mon_e.cyc));
          check({mon_e.name, ".rsp_err"}, 32'(rsp_err), 32'(mon_e.err));
          check({mon_e.name, ".rsp_rdata"}, 32'(rsp_rdata), 32'(mon_e.rdata));
          check({mon_e.name, ".mreq_low"}, 32'(c_mreq), 32'(mon_e.mreq));
          check({mon_e.name, ".ioreq_low"}, 32'(c_ioreq), 32'(mon_e.ioreq));
          check({mon_e.name, ".rd_low"}, 32'(c_rd), 32'(mon_e.rd));
          check({mon_e.name, ".wr_low"}, 32'(c_wr), 32'(mon_e.wr));
          check({mon_e.name, ".m1_low"}, 32'(c_m1), 32'(mon_e.m1));
          check({mon_e.name, ".rfsh_low"}, 32'(c_rfsh), 32'(mon_e.rfsh));
          check({mon_e.name, ".d_oe_high"}, 32'(c_doe), 32'(mon_e.doe));
          if (mon_e.doe > 0) check({mon_e.name, ".d_out"}, 32'(c_dout), 32'(mon_e.dout));
          if (mon_e.mreq + mon_e.ioreq > 0)
            check({mon_e.name, ".bus_addr"}, 32'(c_addr), 32'(mon_e.addr));
          if (mon_e.rfsh > 0) check({mon_e.name, ".refresh_addr"}, 32'(c_refa), 32'(mon_e.refa));
        end
        clear_tally();
      end
    end
  end

  // Issue one request; expected response queued before the accept edge
  task automatic issue(input logic [2:0] op, input logic [15:0] addr, input logic [7:0] wd,
                       input logic [7:0] bd, input int rlow, input exp_t e);
    int budget;
    budget = 0;
    @(negedge CLK);
    while (!req_ready && budget < 200) begin
      @(negedge CLK);
      budget++;
    end
    if (!req_ready) begin
      check({e.name, ".req_ready_wait"}, 32'(req_ready), 32'd1);
      return;
    end
    bus_data    = bd;
    ready_low_n = rlow;
    e.cyc       = cyc + e.lat;
    exp_q.push_back(e);
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    req_op    = OP_MEMWR;
    req_addr  = ~addr;
    req_wdata = ~wd;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 0;
    @(negedge CLK);
    while ((exp_q.size() != 0 || !req_ready) && budget < 300) begin
      @(negedge CLK);
      budget++;
    end
    check({tag, ".drained_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".strobes"}, 32'({MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B}), 32'h3F);
    check({tag, ".d_oe"}, 32'(D_OE), 32'd0);
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ".rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, ".rsp_rdata"}, 32'(rsp_rdata), 32'h00);
    check({tag, ".a"}, 32'(A), 32'h0000);
    check({tag, ".d_out"}, 32'(D_OUT), 32'h00);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("reset");
    RESET = 1'b0;

    // Plain accesses, READY high unless noted
    issue(OP_MEMRD, 16'h4000, 8'h00, 8'hA5, 0,
          mk("memrd", 4, 1'b0, 8'hA5, 2, 0, 2, 0, 0, 0, 0, 8'h00, 16'h4000, 16'h0000));
    issue(OP_MEMWR, 16'hC123, 8'h3C, 8'h00, 3,
          mk("memwr_wait3", 7, 1'b0, 8'hA5, 5, 0, 0, 5, 0, 0, 6, 8'h3C, 16'hC123, 16'h0000));
    issue(OP_IOWR, 16'h7FC4, 8'hC4, 8'h00, 0,
          mk("iowr", 5, 1'b0, 8'hA5, 0, 3, 0, 3, 0, 0, 4, 8'hC4, 16'h7FC4, 16'h0000));
    issue(OP_IORD, 16'h1234, 8'h00, 8'h5A, 0,
          mk("iord", 5, 1'b0, 8'h5A, 0, 3, 3, 0, 0, 0, 0, 8'h00, 16'h1234, 16'h0000));

    // Back-to-back opcode fetches with refresh addresses from R
    issue(OP_FETCH, 16'h0000, 8'h00, 8'h11, 0,
          mk("fetch0", 5, 1'b0, 8'h11, 2, 0, 1, 0, 2, 2, 0, 8'h00, 16'h0000, 16'h0000));
    issue(OP_FETCH, 16'h0001, 8'h00, 8'h22, 0,
          mk("fetch1", 5, 1'b0, 8'h22, 2, 0, 1, 0, 2, 2, 0, 8'h00, 16'h0001, 16'h0001));
    issue(OP_FETCH, 16'h0002, 8'h00, 8'h33, 0,
          mk("fetch2", 5, 1'b0, 8'h33, 2, 0, 1, 0, 2, 2, 0, 8'h00, 16'h0002, 16'h0002));

    // READY stuck low: four TW then T3 with error, then a clean read
    issue(OP_MEMRD, 16'h8000, 8'h00, 8'h77, 255,
          mk("memrd_timeout", 8, 1'b1, 8'h77, 6, 0, 6, 0, 0, 0, 0, 8'h00, 16'h8000, 16'h0000));
    issue(OP_MEMRD, 16'h0100, 8'h00, 8'h99, 0,
          mk("memrd_after_timeout", 4, 1'b0, 8'h99, 2, 0, 2, 0, 0, 0, 0, 8'h00, 16'h0100, 16'h0000));
    drain("before_reset_test");

    // RESET during a TW of an IORD: no response, everything back to reset values
    bus_data    = 8'h44;
    ready_low_n = 255;
    req_op      = OP_IORD;
    req_addr    = 16'h2222;
    req_valid   = 1'b1;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    repeat (4) @(negedge CLK);
    check("mid_reset.in_tw_ioreq_b", 32'(IOREQ_B), 32'd0);
    check("mid_reset.in_tw_rd_b", 32'(RD_B), 32'd0);
    RESET = 1'b1;
    @(negedge CLK);
    check_reset_outputs("mid_reset");
    RESET       = 1'b0;
    ready_low_n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("mid_reset.no_rsp_valid", 32'(rsp_valid), 32'd0);
    end

    // Illegal op: immediate error response, no bus activity, rdata untouched
    issue(3'd6, 16'h1357, 8'hAA, 8'h00, 0,
          mk("illegal_op", 1, 1'b1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0000));
    // R was cleared by reset, so refresh address restarts at 0
    issue(OP_FETCH, 16'h0040, 8'h00, 8'hEE, 0,
          mk("fetch_after_reset", 5, 1'b0, 8'hEE, 2, 0, 1, 0, 2, 2, 0, 8'h00, 16'h0040, 16'h0000));
    drain("end");
    repeat (3) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/z80_bus_initiator.md
# z80_bus_initiator

Z80 bus cycle generator for the CPC expansion connector. It takes single-transfer requests from an on-board controller and drives full Z80 memory, IO and opcode-fetch cycles onto A/D/MREQ_B/IOREQ_B/RD_B/WR_B/M1_B/RFSH_B, honouring READY wait states. It is the initiator end of the bus that the RAM-expansion CPLD decode responds to, and is used for bench and loopback exercise of that decode.

## Interface
- MAX_WAIT, 255: maximum consecutive READY-low wait states before abort (1..255).
- IO_AUTO_WAIT, 1: 1 = insert one unconditional wait state on IO cycles.
- CLK  in  1  bus clock; one CLK cycle = one T-state.
- RESET  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  3  0 MEMRD, 1 MEMWR, 2 IORD, 3 IOWR, 4 FETCH, 5-7 illegal.
- req_addr  in  16  cycle address.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read/fetch data, held until the next read-type completion.
- rsp_err  out  1  valid with rsp_valid; timeout or illegal op.
- A  out  16  address bus.
- D_OUT  out  8  write data; D_OE  out  1  data drive enable.
- D_IN  in  8  bus data.
- MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B  out  1 each  active-low strobes.
- READY  in  1  low = wait; synchronous to CLK, no internal synchroniser.

## Operation
- Handshake: transfer accepted on an edge with req_valid & req_ready. Address, op and wdata are registered at acceptance; later req_* changes are ignored.
- States: IDLE, T1, T2, TWA, TW, T3, T4.
- IDLE: all strobes 1, D_OE 0, A holds the last value.
- T1: A = registered address. Writes drive D_OE = 1 and D_OUT = wdata from T1 through T3. FETCH drives M1_B = 0.
- T2 and TWA/TW for MEM: MREQ_B = 0, plus RD_B = 0 (read, fetch) or WR_B = 0 (write).
- T2 and TWA/TW for IO: IOREQ_B = 0, plus RD_B or WR_B = 0.
- FETCH keeps M1_B = 0 through T2 and TW.
- IO cycles with IO_AUTO_WAIT go T2 -> TWA unconditionally; READY is not sampled at T2.
- READY is sampled at the end of T2 (MEM), TWA (IO) and each TW. 0 -> TW; 1 -> T3.
- Wait counter (8 bits) counts TW cycles. If it equals MAX_WAIT and READY is still 0, the cycle proceeds to T3 with the error flag set.
- MEM/IO T3: strobes stay asserted. Reads capture D_IN into rsp_rdata at the end of T3. Next state is IDLE.
- FETCH: D_IN is captured at the end of the last T2/TW.
  - T3: M1_B = 1, MREQ_B = 1, RD_B = 1, RFSH_B = 0, A = {9'b0, R[6:0]}.
  - T4: RFSH_B = 0, MREQ_B = 0, same A.
  - After T4, R increments modulo 128.
- rsp_valid = 1 in the first IDLE cycle after the last bus state. In that cycle all strobes are high and D_OE = 0.
- Illegal op: accepted, no bus activity. The next cycle is IDLE with rsp_valid = 1, rsp_err = 1, and rsp_rdata unchanged.
- Writes do not change rsp_rdata.

## Timing
- Reset values: req_ready 1, rsp_valid 0, rsp_err 0, rsp_rdata 0x00, A 0x0000, D_OUT 0x00, D_OE 0, all strobes 1, R 0, wait counter 0.
- RESET mid-cycle: on the next edge the state is IDLE and all outputs take their reset values. No rsp_valid is produced for the aborted cycle.
- Latency from the accept edge (cycle k), READY high throughout:
  - MEMRD/MEMWR: T1 k+1, T2 k+2, T3 k+3, rsp_valid k+4.
  - IO with auto wait: rsp_valid k+5.
  - FETCH: T1..T4, rsp_valid k+5.
  - Each READY-low sample adds one cycle.
- Minimum spacing: rsp_valid and req_ready are high in the same IDLE cycle, so a new request can be accepted there. This gives at least one idle T-state between cycles.
- READY going low in T3/T4 has no effect.

## Structure
- Package z80_bus_pkg holds:
  - op encoding constants (OP_MEMRD..OP_FETCH);
  - state enum;
  - REFRESH address layout.
- One sub-module, z80_wait_timer: wait counter, MAX_WAIT compare, timeout flag, cleared in T1.

## Test plan
- MEMRD 0x4000, READY = 1, D_IN = 0xA5 in T3 -> MREQ_B/RD_B low for exactly 2 cycles, rsp_valid at k+4, rsp_rdata 0xA5, rsp_err 0.
- MEMWR 0xC123 data 0x3C, READY low for 3 samples -> WR_B/MREQ_B low for 5 cycles, D_OE high for 6 cycles, D_OUT 0x3C, rsp_valid at k+7.
- IOWR 0x7FC4 data 0xC4 -> IOREQ_B/WR_B low T2+TWA+T3 (3 cycles), MREQ_B never low, rsp_valid k+5.
- Three back-to-back FETCH 0x0000..0x0002 -> M1_B low 2 cycles each; refresh A = 0x0000, 0x0001, 0x0002; RFSH_B low 2 cycles each; fetch data correct.
- MEMRD with READY held low, MAX_WAIT = 4 -> exactly 4 TW, then T3, rsp_err = 1; next request runs normally with rsp_err = 0.
- RESET asserted in TW of an IORD -> next edge strobes all high, D_OE 0, req_ready 1, no rsp_valid. req_op = 6 -> rsp_valid at k+1 with rsp_err = 1, no strobe toggles.
